// File: rtl/apb_if.sv
// apb_if: APB bus bundle between the master and a completer
interface apb_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    sel;
  logic                    enable;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    slverr;
  modport master(output sel, enable, write, strobe, addr, wdata, input ready, rdata, slverr);
  modport slave(input sel, enable, write, strobe, addr, wdata, output ready, rdata, slverr);
endinterface

// File: rtl/apb_slave.sv
// apb_slave: APB completer with byte-strobed register file, wait states and slverr on out-of-range index
module apb_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst_n,
  apb_if.slave bus
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int NB = DATA_WIDTH / 8;
  localparam int MW = $clog2(MEM_DEPTH);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [IW-1:0]         idx;
  logic                  wr;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  setup, legal, done;
  always_comb begin
    setup      = state == IDLE && bus.sel && !bus.enable;
    legal      = 32'(idx) < 32'(MEM_DEPTH);
    bus.ready  = state == ACCESS && cnt == 4'd0;
    done       = bus.ready && bus.sel && bus.enable;
    bus.slverr = bus.ready && !legal;
    bus.rdata  = bus.ready && !wr && legal ? mem[idx[MW-1:0]] : '0;
    state_n    = state;
    cnt_n      = cnt;
    if (setup) begin
      state_n = ACCESS;
      cnt_n   = 4'(WAIT_STATES);
    end else if (state == ACCESS) begin
      if (!bus.sel) state_n = IDLE;
      else if (bus.enable) begin
        cnt_n   = cnt != 4'd0 ? cnt - 4'd1 : cnt;
        state_n = cnt != 4'd0 ? ACCESS : IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // transfer fields are frozen at setup so access-phase bus noise is ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx  <= '0;
      wr   <= 1'b0;
      strb <= '0;
      wd   <= '0;
    end else if (setup) begin
      idx  <= bus.addr[ADDR_WIDTH-1:2];
      wr   <= bus.write;
      strb <= bus.strobe;
      wd   <= bus.wdata;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (done && wr && legal) begin
      for (int b = 0; b < NB; b++)
        if (strb[b]) mem[idx[MW-1:0]][8*b +: 8] <= wd[8*b +: 8];
    end
endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: randomized and directed checks of two completers (0 and 1 wait states) against a word-array model
module tb_apb_slave;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  apb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b0 ();
  apb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b1 ();
  apb_slave #(.WAIT_STATES(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  apb_slave #(.WAIT_STATES(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic        sel [2];
  logic        en  [2];
  logic        wr  [2];
  logic [3:0]  st  [2];
  logic [7:0]  ad  [2];
  logic [31:0] wd  [2];
  assign b0.sel = sel[0];
  assign b0.enable = en[0];
  assign b0.write = wr[0];
  assign b0.strobe = st[0];
  assign b0.addr = ad[0];
  assign b0.wdata = wd[0];
  assign b1.sel = sel[1];
  assign b1.enable = en[1];
  assign b1.write = wr[1];
  assign b1.strobe = st[1];
  assign b1.addr = ad[1];
  assign b1.wdata = wd[1];
  logic [31:0] m [2][32];
  int n_chk = 0;
  int n_fail = 0;
  function automatic logic rdy(int u);
    return u != 0 ? b1.ready : b0.ready;
  endfunction
  function automatic logic err(int u);
    return u != 0 ? b1.slverr : b0.slverr;
  endfunction
  function automatic logic [31:0] rdd(int u);
    return u != 0 ? b1.rdata : b0.rdata;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 32; i++) m[u][i] = '0;
  endtask
  task automatic idle(input int u);
    @(negedge clk);
    sel[u] = 1'b0;
    en[u] = 1'b0;
  endtask
  // Unit u has u wait states, so ready must appear in access cycle u+1.
  task automatic xfer(input int u, input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int acc;
    int ix;
    logic ee;
    logic [31:0] er;
    ix = int'(a[7:2]);
    @(negedge clk);
    sel[u] = 1'b1; en[u] = 1'b0; wr[u] = w; ad[u] = a; wd[u] = d; st[u] = s;
    @(negedge clk);
    en[u] = 1'b1; wr[u] = 1'($urandom); ad[u] = 8'($urandom); wd[u] = $urandom; st[u] = 4'($urandom);
    acc = 1;
    while (!rdy(u) && acc < 40) begin
      @(negedge clk);
      acc++;
    end
    chk("latency", acc, u + 1);
    ee = ix >= 32;
    er = (!w && !ee) ? m[u][ix] : 32'h0;
    chk("slverr", {31'h0, err(u)}, {31'h0, ee});
    if (!w) chk("rdata", rdd(u), er);
    if (w && !ee)
      for (int b = 0; b < 4; b++)
        if (s[b]) m[u][ix][8*b +: 8] = d[8*b +: 8];
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      sel[u] = 0; en[u] = 0; wr[u] = 0; st[u] = 0; ad[u] = 0; wd[u] = 0;
    end
    clear_model();
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_ready", {31'h0, rdy(u)}, 32'h0);
      chk("rst_slverr", {31'h0, err(u)}, 32'h0);
      chk("rst_rdata", rdd(u), 32'h0);
    end
    rst_n = 1'b1;
    xfer(1, 1, 8'h08, 32'hDEADBEEF, 4'hF);
    xfer(1, 0, 8'h08, 32'h0, 4'h0);
    xfer(1, 1, 8'h10, 32'h11223344, 4'hF);
    xfer(1, 1, 8'h10, 32'hAABBCCDD, 4'b0101);
    xfer(1, 0, 8'h10, 32'h0, 4'h0);
    chk("strobe_merge", rdd(1), 32'h11BB33DD);
    xfer(1, 1, 8'h80, 32'h55555555, 4'hF);
    xfer(1, 0, 8'h80, 32'h0, 4'h0);
    idle(1);
    for (int i = 0; i < 3; i++) xfer(0, 1, 8'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 3; i++) xfer(0, 0, 8'(4 * i), 32'h0, 4'h0);
    idle(0);
    repeat (200) begin
      int u;
      u = int'($urandom_range(0, 1));
      xfer(u, 1'($urandom), 8'(4 * $urandom_range(0, 39)), $urandom, 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle(u);
    end
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 32; i++) xfer(u, 0, 8'(4 * i), 32'h0, 4'h0);
      idle(u);
    end
    xfer(1, 1, 8'h0C, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; ad[1] = 8'h0C; wd[1] = 32'h12345678; st[1] = 4'hF;
    @(negedge clk);
    en[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, b1.ready}, 32'h0);
    clear_model();
    @(negedge clk);
    sel[1] = 1'b0; en[1] = 1'b0;
    rst_n = 1'b1;
    xfer(1, 0, 8'h0C, 32'h0, 4'h0);
    idle(1);
    xfer(1, 1, 8'h14, 32'h0BADC0DE, 4'hF);
    @(negedge clk);
    sel[1] = 1'b1; en[1] = 1'b1; wr[1] = 1'b1; ad[1] = 8'h14; wd[1] = 32'hFFFFFFFF; st[1] = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("nosetup_ready", {31'h0, b1.ready}, 32'h0);
    end
    idle(1);
    @(negedge clk);
    sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; ad[1] = 8'h14; wd[1] = 32'h77777777; st[1] = 4'hF;
    @(negedge clk);
    sel[1] = 1'b0; en[1] = 1'b1;
    chk("abort_ready0", {31'h0, b1.ready}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_ready", {31'h0, b1.ready}, 32'h0);
    end
    en[1] = 1'b0;
    xfer(1, 0, 8'h14, 32'h0, 4'h0);
    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
